// File: rtl/fft_pkg.sv
// ----------------------------------------------------------------------------
// fft_pkg
// Shared types and helpers for the FFT datapath.
//   ser_state_t  : two-state FSM encoding of the point serializer
//   bit_reverse  : reverses the low nbits of value; also used by the crossbar
//                  stage indexing
// ----------------------------------------------------------------------------
package fft_pkg;

    typedef enum logic {SER_IDLE, SER_SEND} ser_state_t;

    function automatic logic [31:0] bit_reverse(input logic [31:0] value, input int nbits);
        logic [31:0] result;
        result = '0;
        for (int i = 0; i < nbits; i++) begin
            result[i] = value[nbits-1-i];
        end
        return result;
    endfunction

endpackage

// File: rtl/fft_point_serializer_if.sv
// ----------------------------------------------------------------------------
// fft_point_serializer_if
// Wide-frame receive channel plus narrow point send channel of the serializer.
//   recv_msg  : flat frame, real[k] at [BW*(N+k) +: BW], imag[k] at [BW*k +: BW]
//   recv_val / recv_rdy : frame handshake
//   send_msg  : {real, imag} of the current point
//   send_val / send_rdy : point handshake
//   send_last : high with the final point of a frame
// Modports: master = producer/consumer side (bench), slave = serializer.
// ----------------------------------------------------------------------------
interface fft_point_serializer_if #(
    parameter int BIT_WIDTH = 32,
    parameter int SIZE_FFT  = 8
);
    logic [BIT_WIDTH*SIZE_FFT*2-1:0] recv_msg;
    logic                            recv_val;
    logic                            recv_rdy;
    logic [2*BIT_WIDTH-1:0]          send_msg;
    logic                            send_val;
    logic                            send_rdy;
    logic                            send_last;

    modport master (
        output recv_msg, recv_val, send_rdy,
        input  recv_rdy, send_msg, send_val, send_last
    );

    modport slave (
        input  recv_msg, recv_val, send_rdy,
        output recv_rdy, send_msg, send_val, send_last
    );
endinterface

// File: rtl/fft_bit_reverse_index.sv
// ----------------------------------------------------------------------------
// fft_bit_reverse_index
// Combinational map from a point counter to its bit-reversed index over
// $clog2(N) bits.
//   i_cnt : natural-order point counter
//   o_idx : bit-reversed point index
// ----------------------------------------------------------------------------
module fft_bit_reverse_index
    import fft_pkg::*;
#(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [W-1:0] i_cnt,
    output logic [W-1:0] o_idx
);
    assign o_idx = W'(bit_reverse(32'(i_cnt), W));
endmodule

// File: rtl/fft_point_serializer.sv
// ----------------------------------------------------------------------------
// fft_point_serializer
// Accepts one SIZE_FFT-point complex frame and streams it out one complex
// point per beat. A new frame may be accepted on the same cycle the last
// point of the current frame is consumed, so frames stream without bubbles.
//   clk   : clock
//   reset : synchronous, active-high reset
//   bus   : fft_point_serializer_if.slave (recv frame channel, send point channel)
// Build option: define FFT_SERIALIZER_BITREV_EN to emit points in bit-reversed
// order; otherwise points leave in natural order.
// ----------------------------------------------------------------------------
module fft_point_serializer
    import fft_pkg::*;
#(
    parameter int BIT_WIDTH = 32,
    parameter int SIZE_FFT  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    fft_point_serializer_if.slave bus
);
    localparam int               CNT_W    = $clog2(SIZE_FFT);
    localparam int               FRAME_W  = BIT_WIDTH * SIZE_FFT * 2;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SIZE_FFT - 1);

    ser_state_t           r_state;
    ser_state_t           w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_idx;
    logic [FRAME_W-1:0]   r_frame;
    logic [BIT_WIDTH-1:0] w_real [SIZE_FFT];
    logic [BIT_WIDTH-1:0] w_imag [SIZE_FFT];
    logic                 w_last;
    logic                 w_send_val;
    logic                 w_send_fire;
    logic                 w_recv_rdy;
    logic                 w_recv_fire;

    // Handshake terms. Outputs are gated by reset so nothing is offered or
    // accepted while reset is held.
    assign w_last      = (r_cnt == LAST_CNT);
    assign w_send_val  = !reset && (r_state == SER_SEND);
    assign w_send_fire = w_send_val && bus.send_rdy;
    // Accepting during the final point's fire is what removes the bubble.
    assign w_recv_rdy  = !reset && ((r_state == SER_IDLE) || (w_send_fire && w_last));
    assign w_recv_fire = bus.recv_val && w_recv_rdy;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SER_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SER_IDLE: if (w_recv_fire) w_state_next = SER_SEND;
            SER_SEND: if (w_send_fire && w_last && !w_recv_fire) w_state_next = SER_IDLE;
            default:  w_state_next = SER_IDLE;
        endcase
    end

    // NOTE: the frame buffer is reset (unlike a typical data store) because
    // send_msg must read zero out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_frame <= '0;
        end else if (w_recv_fire) begin
            r_cnt   <= '0;
            r_frame <= bus.recv_msg;
        end else if (w_send_fire) begin
            r_cnt   <= w_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

    // Unpack the flat frame into per-point real/imag lanes.
    for (genvar k = 0; k < SIZE_FFT; k++) begin : g_lane
        assign w_real[k] = r_frame[BIT_WIDTH*(SIZE_FFT+k) +: BIT_WIDTH];
        assign w_imag[k] = r_frame[BIT_WIDTH*k +: BIT_WIDTH];
    end

`ifdef FFT_SERIALIZER_BITREV_EN
    fft_bit_reverse_index #(.N(SIZE_FFT)) u_bit_reverse_index (
        .i_cnt (r_cnt),
        .o_idx (w_idx)
    );
`else
    assign w_idx = r_cnt;
`endif

    assign bus.recv_rdy  = w_recv_rdy;
    assign bus.send_val  = w_send_val;
    assign bus.send_last = w_send_val && w_last;
    assign bus.send_msg  = {w_real[w_idx], w_imag[w_idx]};
endmodule

// File: tb/tb_fft_point_serializer.sv
// ----------------------------------------------------------------------------
// tb_fft_point_serializer
// Self-checking bench for fft_point_serializer (BIT_WIDTH=32, SIZE_FFT=8).
// A reference model keeps a queue of the points still owed by the serializer;
// every cycle it predicts send_val, recv_rdy, send_msg and send_last from that
// queue and the frame packing rules.
// ----------------------------------------------------------------------------
module tb_fft_point_serializer;
    localparam int BW  = 32;
    localparam int N   = 8;
    localparam int LOG = 3;
    localparam int FW  = BW * N * 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fft_point_serializer_if #(.BIT_WIDTH(BW), .SIZE_FFT(N)) bus ();

    fft_point_serializer #(.BIT_WIDTH(BW), .SIZE_FFT(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output order of points: beat b carries point index point_index(b).
    function automatic int point_index(input int b);
        int rev;
        int v;
`ifdef FFT_SERIALIZER_BITREV_EN
        rev = 0;
        v   = b;
        for (int j = 0; j < LOG; j++) begin
            rev = rev * 2 + (v % 2);
            v   = v / 2;
        end
        return rev;
`else
        rev = b;
        v   = 0;
        return rev + v;
`endif
    endfunction

    function automatic logic [FW-1:0] rand_frame();
        logic [FW-1:0] f;
        for (int w = 0; w < FW / 32; w++) f[w*32 +: 32] = $urandom();
        return f;
    endfunction

    function automatic logic [FW-1:0] ramp_frame();
        logic [FW-1:0] f;
        f = '0;
        for (int k = 0; k < N; k++) begin
            f[BW*(N+k) +: BW] = BW'(k + 1);
            f[BW*k +: BW]     = BW'(32'h100 + k);
        end
        return f;
    endfunction

    // Reference model: queue of {last, real, imag} still to be delivered.
    logic [64:0] exp_q[$];
    int          beats = 0;

    always @(negedge clk) begin
        bit exp_val;
        bit exp_rdy;
        int k;
        if (reset) begin
            check("rst_recv_rdy", 64'(bus.recv_rdy), 64'd0);
            check("rst_send_val", 64'(bus.send_val), 64'd0);
            exp_q.delete();
        end else begin
            exp_val = (exp_q.size() != 0);
            exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && bus.send_rdy);
            check("send_val", 64'(bus.send_val), 64'(exp_val));
            check("recv_rdy", 64'(bus.recv_rdy), 64'(exp_rdy));
            if (exp_val) begin
                check("send_msg",  bus.send_msg,         exp_q[0][63:0]);
                check("send_last", 64'(bus.send_last), 64'(exp_q[0][64]));
                if (bus.send_rdy) begin
                    void'(exp_q.pop_front());
                    beats++;
                end
            end
            if (bus.recv_val && exp_rdy) begin
                for (int b = 0; b < N; b++) begin
                    k = point_index(b);
                    exp_q.push_back({b == N - 1, bus.recv_msg[BW*(N+k) +: BW], bus.recv_msg[BW*k +: BW]});
                end
            end
        end
    end

    // send_rdy generator: 0 = always ready, 1 = pattern 1,0,0, 2 = random.
    int rdy_mode = 0;
    initial begin
        int phase;
        phase = 0;
        bus.send_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       bus.send_rdy = (phase % 3 == 0);
                2:       bus.send_rdy = 1'($urandom_range(0, 1));
                default: bus.send_rdy = 1'b1;
            endcase
            phase++;
        end
    end

    // Present a frame and hold it until accepted; recv_val stays high afterwards.
    task automatic send_frame(input logic [FW-1:0] f);
        int budget;
        budget = 0;
        bus.recv_val = 1'b1;
        bus.recv_msg = f;
        do begin
            @(negedge clk);
            budget++;
        end while (!bus.recv_rdy && budget < 300);
        check("accept_timeout", 64'(bus.recv_rdy), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_recv();
        bus.recv_val = 1'b0;
        bus.recv_msg = rand_frame();
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        check("drain_timeout", 64'(exp_q.size() == 0), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int b0;
        int budget;
        // 1: reset held two cycles with recv_val high
        reset        = 1'b1;
        bus.recv_val = 1'b1;
        bus.recv_msg = rand_frame();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        idle_recv();
        @(posedge clk);
        #1;

        // 2: single ramp frame, always ready
        rdy_mode = 0;
        b0 = beats;
        send_frame(ramp_frame());
        idle_recv();
        wait_drain();
        check("single_beats", 64'(beats - b0), 64'd8);

        // 3: backpressure 1,0,0
        rdy_mode = 1;
        b0 = beats;
        send_frame(rand_frame());
        idle_recv();
        wait_drain();
        check("bp_beats", 64'(beats - b0), 64'd8);

        // 4: back-to-back frames, always ready
        rdy_mode = 0;
        b0 = beats;
        send_frame(rand_frame());
        send_frame(rand_frame());
        check("b2b_accept_at_last", 64'(beats - b0), 64'd8);
        idle_recv();
        wait_drain();
        check("b2b_beats", 64'(beats - b0), 64'd16);

        // 5: reset after beat 3
        b0 = beats;
        send_frame(rand_frame());
        idle_recv();
        budget = 0;
        while (beats - b0 < 3 && budget < 50) begin
            @(posedge clk);
            budget++;
        end
        check("mid_beats", 64'(beats - b0), 64'd3);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send_frame(ramp_frame());
        idle_recv();
        wait_drain();

        // 6: 20 idle cycles with changing recv_msg, then a normal frame
        repeat (20) begin
            @(posedge clk);
            #1;
            bus.recv_msg = rand_frame();
        end
        b0 = beats;
        send_frame(ramp_frame());
        idle_recv();
        wait_drain();
        check("idle_beats", 64'(beats - b0), 64'd8);

        // 7: random frames, random readiness, random gaps (0 = back-to-back)
        rdy_mode = 2;
        for (int f = 0; f < 30; f++) begin
            int gap;
            send_frame(rand_frame());
            gap = $urandom_range(0, 3);
            if (gap != 0) begin
                idle_recv();
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        idle_recv();
        wait_drain();

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
